// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: EX control, instruction-memory port and the IF/EX register.
// The master modport is the fetch stage; the slave modport is everything around it.
interface fetch_stage_if;
  logic        stall;
  logic        should_br;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    input  stall, should_br, br_target, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output stall, should_br, br_target, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_inst
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, kill on redirect,
// a one-entry skid buffer for stalls, and a registered IF/EX output.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_kill;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;

  state_t      w_state_seq;
  state_t      w_state_nxt;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_req_pc_nxt;
  logic        w_kill_seq;
  logic        w_kill_nxt;
  logic [31:0] w_skid_pc_seq;
  logic [31:0] w_skid_inst_seq;
  logic [31:0] w_skid_pc_nxt;
  logic [31:0] w_skid_inst_nxt;
  logic        w_load;
  logic [31:0] w_load_pc;
  logic [31:0] w_load_inst;
  logic        w_if_valid_nxt;
  logic [31:0] w_if_pc_nxt;
  logic [31:0] w_if_inst_nxt;
  logic        w_req_nxt;
  logic        w_grant;
  logic [31:0] w_pc_inc;
  logic [31:0] w_br_pc;
  logic        w_unused_tgt;

  assign w_grant      = r_req & bus.imem_gnt;
  assign w_pc_inc     = r_req_pc + 32'd4;
  assign w_br_pc      = {bus.br_target[31:2], 2'b00};
  assign w_unused_tgt = ^bus.br_target[1:0];

  // Fetch sequencing without redirect: grant, response, stall capture, skid drain.
  always_comb begin
    w_state_seq     = r_state;
    w_pc_seq        = r_pc;
    w_req_pc_nxt    = r_req_pc;
    w_kill_seq      = r_kill;
    w_skid_pc_seq   = r_skid_pc;
    w_skid_inst_seq = r_skid_inst;
    w_load          = 1'b0;
    w_load_pc       = r_req_pc;
    w_load_inst     = bus.imem_rdata;
    case (r_state)
      ST_ISSUE: begin
        if (w_grant) begin
          w_state_seq  = ST_WAIT;
          w_req_pc_nxt = r_pc;
        end else begin
          w_state_seq  = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          if (r_kill) begin
            // PC already holds the redirect target; the response is stale.
            w_kill_seq  = 1'b0;
            w_state_seq = ST_ISSUE;
          end else if (!bus.stall) begin
            w_load      = 1'b1;
            w_pc_seq    = w_pc_inc;
            w_state_seq = ST_ISSUE;
          end else begin
            w_skid_pc_seq   = r_req_pc;
            w_skid_inst_seq = bus.imem_rdata;
            w_pc_seq        = w_pc_inc;
            w_state_seq     = ST_HOLD;
          end
        end else begin
          w_state_seq = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (!bus.stall) begin
          w_load      = 1'b1;
          w_load_pc   = r_skid_pc;
          w_load_inst = r_skid_inst;
          w_state_seq = ST_ISSUE;
        end else begin
          w_state_seq = ST_HOLD;
        end
      end
      default: begin
        w_state_seq = ST_ISSUE;
        w_kill_seq  = 1'b0;
      end
    endcase
  end

  // Redirect overrides every other event, including stall.
  always_comb begin
    w_state_nxt     = w_state_seq;
    w_pc_nxt        = w_pc_seq;
    w_kill_nxt      = w_kill_seq;
    w_skid_pc_nxt   = w_skid_pc_seq;
    w_skid_inst_nxt = w_skid_inst_seq;
    if (bus.should_br) begin
      w_pc_nxt        = w_br_pc;
      w_skid_pc_nxt   = 32'd0;
      w_skid_inst_nxt = 32'd0;
      case (r_state)
        ST_ISSUE: begin
          w_state_nxt = w_grant ? ST_WAIT : ST_ISSUE;
          w_kill_nxt  = w_grant;
        end
        ST_WAIT: begin
          w_state_nxt = bus.imem_rvalid ? ST_ISSUE : ST_WAIT;
          w_kill_nxt  = ~bus.imem_rvalid;
        end
        ST_HOLD: begin
          w_state_nxt = ST_ISSUE;
          w_kill_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = ST_ISSUE;
          w_kill_nxt  = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = w_state_seq;
      w_kill_nxt  = w_kill_seq;
    end
  end

  // IF/EX next value: bubble on redirect, load, bubble when free, else hold.
  always_comb begin
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_inst_nxt  = r_if_inst;
    if (bus.should_br) begin
      w_if_valid_nxt = 1'b0;
      w_if_inst_nxt  = NOP_INST;
    end else if (w_load) begin
      w_if_valid_nxt = 1'b1;
      w_if_pc_nxt    = w_load_pc;
      w_if_inst_nxt  = w_load_inst;
    end else if (!bus.stall) begin
      w_if_valid_nxt = 1'b0;
      w_if_inst_nxt  = NOP_INST;
    end else begin
      w_if_valid_nxt = r_if_valid;
    end
  end

  assign w_req_nxt = (w_state_nxt == ST_ISSUE);

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ISSUE;
      r_req       <= 1'b0;
      r_pc        <= RESET_PC;
      r_req_pc    <= 32'd0;
      r_kill      <= 1'b0;
      r_skid_pc   <= 32'd0;
      r_skid_inst <= 32'd0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= 32'd0;
      r_if_inst   <= NOP_INST;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_kill      <= w_kill_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      r_skid_inst <= w_skid_inst_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_if_inst   <= w_if_inst_nxt;
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_inst   = r_if_inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: a cycle table plus hand sequences
// for reset mid-request and PC wrap-around.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus();
  fetch_stage_if bus2();

  fetch_stage u_dut (.clk(clk), .rst(rst), .bus(bus));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic g, logic r, logic [31:0] d,
                              logic eq, logic [31:0] ea, logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.gnt = g; x.rv = r; x.rdata = d;
    x.req = eq; x.addr = ea; x.v = ev; x.pc = ep; x.inst = ei;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic eq, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    chk({tag, " imem_req"},  {31'd0, bus.imem_req}, {31'd0, eq});
    chk({tag, " imem_addr"}, bus.imem_addr, ea);
    chk({tag, " if_valid"},  {31'd0, bus.if_valid}, {31'd0, ev});
    chk({tag, " if_pc"},     bus.if_pc, ep);
    chk({tag, " if_inst"},   bus.if_inst, ei);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // stall br tgt gnt rv rdata | req addr v pc inst
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h2000,0,0,NOP));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,0,0,0,0,0, 1,32'h2000,0,0,NOP));
    vecs.push_back(mk(0,0,0,1,0,0,                      0,32'h2000,0,0,NOP));
    vecs.push_back(mk(0,0,0,1,1,32'h0000_0093,          1,32'h2004,1,32'h2000,32'h0000_0093));
    vecs.push_back(mk(0,0,0,1,0,0,                      0,32'h2004,0,32'h2000,NOP));
    vecs.push_back(mk(1,0,0,1,1,32'h0000_0193,          0,32'h2008,0,32'h2000,NOP));
    vecs.push_back(mk(1,0,0,1,0,0,                      0,32'h2008,0,32'h2000,NOP));
    vecs.push_back(mk(1,0,0,1,0,0,                      0,32'h2008,0,32'h2000,NOP));
    vecs.push_back(mk(0,0,0,1,0,0,                      1,32'h2008,1,32'h2004,32'h0000_0193));
    vecs.push_back(mk(0,0,0,1,0,0,                      0,32'h2008,0,32'h2004,NOP));
    vecs.push_back(mk(0,1,32'h3006,1,0,0,               0,32'h3004,0,32'h2004,NOP));
    vecs.push_back(mk(0,0,0,1,1,32'h0000_0293,          1,32'h3004,0,32'h2004,NOP));
    vecs.push_back(mk(0,0,0,1,0,0,                      0,32'h3004,0,32'h2004,NOP));
    vecs.push_back(mk(0,0,0,1,1,32'h0000_0393,          1,32'h3008,1,32'h3004,32'h0000_0393));
    vecs.push_back(mk(0,0,0,1,0,0,                      0,32'h3008,0,32'h3004,NOP));
    vecs.push_back(mk(1,1,32'h4000,1,1,32'h0000_0493,   1,32'h4000,0,32'h3004,NOP));
    vecs.push_back(mk(0,0,0,1,0,0,                      0,32'h4000,0,32'h3004,NOP));
    vecs.push_back(mk(0,0,0,1,1,32'h0000_0593,          1,32'h4004,1,32'h4000,32'h0000_0593));
    vecs.push_back(mk(0,1,32'h5000,0,0,0,               1,32'h5000,0,32'h4000,NOP));
    vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h5000,0,32'h4000,NOP));
    vecs.push_back(mk(0,1,32'h6000,1,0,0,               0,32'h6000,0,32'h4000,NOP));
    vecs.push_back(mk(0,0,0,1,1,32'h0000_0693,          1,32'h6000,0,32'h4000,NOP));
    vecs.push_back(mk(0,0,0,1,0,0,                      0,32'h6000,0,32'h4000,NOP));
    vecs.push_back(mk(1,0,0,1,1,32'h0000_0793,          0,32'h6004,0,32'h4000,NOP));
    vecs.push_back(mk(1,1,32'h7000,1,0,0,               1,32'h7000,0,32'h4000,NOP));
    vecs.push_back(mk(0,0,0,1,0,0,                      0,32'h7000,0,32'h4000,NOP));
    vecs.push_back(mk(0,0,0,1,1,32'h0000_0893,          1,32'h7004,1,32'h7000,32'h0000_0893));
    vecs.push_back(mk(1,0,0,0,0,0,                      1,32'h7004,1,32'h7000,32'h0000_0893));
    vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h7004,0,32'h7000,NOP));

    bus.stall = 1'b0; bus.should_br = 1'b0; bus.br_target = 32'd0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    bus2.stall = 1'b0; bus2.should_br = 1'b0; bus2.br_target = 32'd0;
    bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'd0;

    // Reset values while rst is held low.
    cyc();
    cyc();
    chk_out("reset", 1'b0, 32'h2000, 1'b0, 32'd0, NOP);
    rst = 1'b1;

    foreach (vecs[i]) begin
      bus.stall       = vecs[i].stall;
      bus.should_br   = vecs[i].br;
      bus.br_target   = vecs[i].tgt;
      bus.imem_gnt    = vecs[i].gnt;
      bus.imem_rvalid = vecs[i].rv;
      bus.imem_rdata  = vecs[i].rdata;
      cyc();
      chk_out($sformatf("row%0d", i), vecs[i].req, vecs[i].addr, vecs[i].v, vecs[i].pc, vecs[i].inst);
    end

    // Reset in the middle of an outstanding request; a late response must be ignored.
    bus.stall = 1'b0; bus.should_br = 1'b0; bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0;
    cyc();
    chk("midwait imem_req", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h2000, 1'b0, 32'd0, NOP);
    cyc();
    rst = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    chk_out("late_rvalid", 1'b1, 32'h2000, 1'b0, 32'd0, NOP);
    bus.imem_rvalid = 1'b0;
    cyc();
    chk_out("late_rvalid2", 1'b1, 32'h2000, 1'b0, 32'd0, NOP);

    // PC increment wraps from the top of the address space.
    chk("wrap first addr", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("wrap first req", {31'd0, bus2.imem_req}, 32'd1);
    bus2.imem_gnt = 1'b1;
    cyc();
    chk("wrap wait req", {31'd0, bus2.imem_req}, 32'd0);
    bus2.imem_gnt    = 1'b0;
    bus2.imem_rvalid = 1'b1;
    bus2.imem_rdata  = 32'h0000_0A93;
    cyc();
    bus2.imem_rvalid = 1'b0;
    chk("wrap second addr", bus2.imem_addr, 32'h0000_0000);
    chk("wrap second req", {31'd0, bus2.imem_req}, 32'd1);
    chk("wrap if_valid", {31'd0, bus2.if_valid}, 32'd1);
    chk("wrap if_pc", bus2.if_pc, 32'hFFFF_FFFC);
    chk("wrap if_inst", bus2.if_inst, 32'h0000_0A93);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_2000: first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0): instruction presented on bubbles.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous reset, active-low.
REQ-005 stall  in  1  EX cannot accept; hold IF/EX register contents.
REQ-006 should_br  in  1  EX branch/jump resolved taken this cycle.
REQ-007 br_target  in  32  redirect address from EX, valid when should_br=1.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  32  word address of request.
REQ-010 imem_gnt  in  1  memory accepts request this cycle.
REQ-011 imem_rvalid  in  1  read data valid, at least 1 cycle after grant.
REQ-012 imem_rdata  in  32  read data.
REQ-013 if_valid  out  1  IF/EX register holds a real instruction.
REQ-014 if_pc  out  32  PC of instruction in IF/EX register.
REQ-015 if_inst  out  32  instruction in IF/EX register; NOP_INST when if_valid=0.

Function
REQ-016 The block SHALL keep a fetch PC register, a 3-state FSM (ISSUE, WAIT, HOLD), a kill flag, a 64-bit skid buffer {pc,inst}, and the IF/EX register {if_valid,if_pc,if_inst}.
REQ-017 At most one memory request SHALL be outstanding; imem_req=1 only in ISSUE, with imem_addr=PC.
REQ-018 ISSUE: imem_req&imem_gnt -> WAIT, latch request PC; no grant -> stay ISSUE, imem_addr unchanged unless redirected.
REQ-019 WAIT, imem_rvalid, kill=0, stall=0: IF/EX <= {1, req PC, imem_rdata}; PC <= req PC+4; -> ISSUE.
REQ-020 WAIT, imem_rvalid, kill=0, stall=1: skid <= {req PC, imem_rdata}; PC <= req PC+4; -> HOLD.
REQ-021 WAIT, imem_rvalid, kill=1: data discarded, kill cleared, -> ISSUE (PC already holds target).
REQ-022 HOLD, stall=0: IF/EX <= {1, skid}; -> ISSUE; HOLD, stall=1: stay, no request issued.
REQ-023 Whenever stall=0 and no instruction is loaded that cycle, IF/EX SHALL become {0, unchanged if_pc, NOP_INST}; when stall=1 IF/EX SHALL hold.
REQ-024 should_br=1 SHALL override stall and all other events: PC <= {br_target[31:2],2'b00}; IF/EX <= {0, if_pc, NOP_INST}; skid discarded.
REQ-025 Redirect in ISSUE without grant: -> ISSUE, next imem_addr = target; with grant same cycle: -> WAIT, kill=1.
REQ-026 Redirect in WAIT without rvalid: stay WAIT, kill=1; with rvalid same cycle: data discarded, -> ISSUE, kill=0.
REQ-027 Redirect in HOLD: -> ISSUE, skid discarded.
REQ-028 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-029 Throughput with 1-cycle memory and no stall: one instruction per 2 cycles (ISSUE, WAIT).

Reset
REQ-030 While rst=0: state=ISSUE, PC=RESET_PC, kill=0, imem_req=0, if_valid=0, if_pc=0, if_inst=NOP_INST, skid cleared.
REQ-031 First request SHALL assert on the first clk edge after rst deasserts, with imem_addr=RESET_PC.
REQ-032 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late imem_rvalid after reset release with state ISSUE SHALL be ignored.

Verification
REQ-033 Reset release, gnt tied 1, rvalid 1 cycle after grant, rdata=32'h0000_0093 -> imem_addr 2000,2004,2008; if_valid pulses with if_pc=2000 then 2004, if_inst=0000_0093.
REQ-034 stall=1 for 3 cycles when rvalid for 2004 arrives -> state HOLD, no imem_req, if_pc stays 2000; stall=0 -> if_pc=2004, if_valid=1 next edge.
REQ-035 should_br=1, br_target=32'h0000_3006 while WAIT on 2008 -> kill set, returning 2008 data dropped, next imem_addr=3004, if_valid=0 until 3004 returns.
REQ-036 should_br=1 same cycle as imem_rvalid with stall=1 -> no HOLD entry, skid empty, next imem_addr=target.
REQ-037 imem_gnt held 0 for 4 cycles -> imem_req=1, imem_addr stable at 2000 throughout; if_valid=0.
REQ-038 RESET_PC=32'hFFFF_FFFC -> second request imem_addr=32'h0000_0000.
